// File: rtl/parity_pkg.sv
// parity_pkg: shared widths and output-buffer state for the parity receiver
package parity_pkg;
    localparam int DATA_W  = 7;
    localparam int FRAME_W = 8;
    typedef enum logic {EMPTY, FULL} buf_state_t;
endpackage

// File: rtl/parity_rx_if.sv
// parity_rx_if: serial input and output-buffer handshake of the parity receiver
interface parity_rx_if;
    import parity_pkg::*;
    logic              sin;
    logic              sin_valid;
    logic              clr;
    logic              out_ready;
    logic [DATA_W-1:0] data;
    logic              par_err;
    logic              out_valid;
    logic              overrun;
    modport master (output sin, sin_valid, clr, out_ready, input data, par_err, out_valid, overrun);
    modport slave  (input sin, sin_valid, clr, out_ready, output data, par_err, out_valid, overrun);
endinterface

// File: rtl/parity_deser.sv
// parity_deser: LSB-first shift register, bit counter and running XOR for one frame
module parity_deser import parity_pkg::*; #(
    parameter bit ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sin,
    input  logic              i_sin_valid,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_par_err,
    output logic              o_done
);
    logic [DATA_W-1:0] r_shift;
    logic [2:0]        r_cnt;
    logic              r_xor;
    logic              w_accept;
    assign w_accept  = i_sin_valid && !i_clr;
    assign o_done    = w_accept && r_cnt == 3'(FRAME_W - 1);
    assign o_data    = r_shift;
    assign o_par_err = (r_xor ^ i_sin) != ODD_PARITY;
    // the parity bit is never shifted in, so r_shift holds exactly the 7 data bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_xor   <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_xor <= 1'b0;
        end else if (i_sin_valid) begin
            r_cnt <= r_cnt + 1'b1;
            r_xor <= o_done ? 1'b0 : r_xor ^ i_sin;
            if (!o_done) r_shift <= {i_sin, r_shift[DATA_W-1:1]};
        end
    end
endmodule

// File: rtl/parity_rx.sv
// parity_rx: serial parity-checked frame receiver with a one-entry output buffer
module parity_rx import parity_pkg::*; #(
    parameter bit ODD_PARITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    parity_rx_if.slave  bus
);
    logic [DATA_W-1:0] w_data;
    logic              w_par_err;
    logic              w_done;
    logic              w_hs;
    buf_state_t        r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_par_err;
    logic              r_overrun;
    parity_deser #(.ODD_PARITY(ODD_PARITY)) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sin      (bus.sin),
        .i_sin_valid(bus.sin_valid),
        .i_clr      (bus.clr),
        .o_data     (w_data),
        .o_par_err  (w_par_err),
        .o_done     (w_done)
    );
    assign w_hs = r_state == FULL && bus.out_ready;
    // a completing frame may replace the held one only if it is consumed this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_par_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_done && r_state == FULL && !bus.out_ready;
            if (w_done && (r_state == EMPTY || bus.out_ready)) begin
                r_data    <= w_data;
                r_par_err <= w_par_err;
                r_state   <= FULL;
            end else if (w_hs) begin
                r_state <= EMPTY;
            end
        end
    end
    assign bus.data      = r_data;
    assign bus.par_err   = r_par_err;
    assign bus.out_valid = r_state == FULL;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed checks of even- and odd-parity receivers fed identical streams
module tb_parity_rx;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    parity_rx_if if_e ();
    parity_rx_if if_o ();
    parity_rx #(.ODD_PARITY(0)) u_even (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));
    parity_rx #(.ODD_PARITY(1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(if_o.slave));
    assign if_o.sin       = if_e.sin;
    assign if_o.sin_valid = if_e.sin_valid;
    assign if_o.clr       = if_e.clr;
    assign if_o.out_ready = if_e.out_ready;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send_bit(input logic b);
        if_e.sin       = b;
        if_e.sin_valid = 1'b1;
        step();
        if_e.sin_valid = 1'b0;
    endtask
    task automatic send_frame(input logic [6:0] d, input logic p, input int max_gap);
        logic [7:0] f;
        f = {p, d};
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(max_gap, 0)) step();
            send_bit(f[i]);
        end
    endtask
    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        if_e.sin       = 1'b0;
        if_e.sin_valid = 1'b0;
        if_e.clr       = 1'b0;
        if_e.out_ready = 1'b0;
        #3;
        chk("rst_valid", {7'd0, if_e.out_valid}, 8'd0);
        chk("rst_data", {1'b0, if_e.data}, 8'd0);
        chk("rst_perr", {7'd0, if_e.par_err}, 8'd0);
        chk("rst_ovr", {7'd0, if_e.overrun}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // 0x55 with correct even parity, consumer always ready
        if_e.out_ready = 1'b1;
        send_frame(7'h55, 1'b0, 0);
        chk("f55_valid", {7'd0, if_e.out_valid}, 8'd1);
        chk("f55_data", {1'b0, if_e.data}, 8'h55);
        chk("f55_perr_even", {7'd0, if_e.par_err}, 8'd0);
        chk("f55_perr_odd", {7'd0, if_o.par_err}, 8'd1);
        step();
        chk("f55_consumed", {7'd0, if_e.out_valid}, 8'd0);
        // same data, parity bit 1
        send_frame(7'h55, 1'b1, 0);
        chk("f55p1_data", {1'b0, if_e.data}, 8'h55);
        chk("f55p1_perr_even", {7'd0, if_e.par_err}, 8'd1);
        chk("f55p1_perr_odd", {7'd0, if_o.par_err}, 8'd0);
        step();
        // overrun: 0x01 held, 0x7F dropped
        if_e.out_ready = 1'b0;
        send_frame(7'h01, 1'b1, 0);
        chk("ovr_first_valid", {7'd0, if_e.out_valid}, 8'd1);
        chk("ovr_first_data", {1'b0, if_e.data}, 8'h01);
        chk("ovr_no_pulse_yet", {7'd0, if_e.overrun}, 8'd0);
        send_frame(7'h7F, 1'b1, 0);
        chk("ovr_pulse", {7'd0, if_e.overrun}, 8'd1);
        chk("ovr_data_kept", {1'b0, if_e.data}, 8'h01);
        step();
        chk("ovr_pulse_end", {7'd0, if_e.overrun}, 8'd0);
        chk("ovr_still_valid", {7'd0, if_e.out_valid}, 8'd1);
        chk("ovr_still_data", {1'b0, if_e.data}, 8'h01);
        if_e.out_ready = 1'b1;
        step();
        chk("ovr_drained", {7'd0, if_e.out_valid}, 8'd0);
        // handshake in the same cycle 0x7F completes
        if_e.out_ready = 1'b0;
        send_frame(7'h01, 1'b1, 0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        if_e.out_ready = 1'b1;
        send_bit(1'b1);
        chk("sim_data", {1'b0, if_e.data}, 8'h7F);
        chk("sim_valid", {7'd0, if_e.out_valid}, 8'd1);
        chk("sim_ovr", {7'd0, if_e.overrun}, 8'd0);
        chk("sim_perr", {7'd0, if_e.par_err}, 8'd0);
        step();
        chk("sim_drained", {7'd0, if_e.out_valid}, 8'd0);
        // partial frame aborted by clr, clr beating a valid bit
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        if_e.clr = 1'b1;
        send_bit(1'b1);
        if_e.clr = 1'b0;
        chk("clr_no_frame", {7'd0, if_e.out_valid}, 8'd0);
        send_frame(7'h2A, 1'b1, 0);
        chk("clr_data", {1'b0, if_e.data}, 8'h2A);
        chk("clr_perr", {7'd0, if_e.par_err}, 8'd0);
        step();
        // asynchronous reset mid-frame while a frame is held
        if_e.out_ready = 1'b0;
        send_frame(7'h33, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, if_e.out_valid}, 8'd0);
        chk("arst_data", {1'b0, if_e.data}, 8'd0);
        chk("arst_perr", {7'd0, if_e.par_err}, 8'd0);
        chk("arst_ovr", {7'd0, if_e.overrun}, 8'd0);
        #1 rst_n = 1'b1;
        if_e.out_ready = 1'b1;
        send_frame(7'h15, 1'b1, 0);
        chk("post_rst_data", {1'b0, if_e.data}, 8'h15);
        chk("post_rst_perr", {7'd0, if_e.par_err}, 8'd0);
        step();
        // every data value, correct and flipped parity, random gaps
        for (int v = 0; v < 128; v++) begin
            for (int f = 0; f < 2; f++) begin
                logic [6:0] d;
                logic       fl;
                d  = 7'(v);
                fl = f[0];
                send_frame(d, ^d ^ fl, 2);
                chk("exh_valid", {7'd0, if_e.out_valid}, 8'd1);
                chk("exh_data", {1'b0, if_e.data}, {1'b0, d});
                chk("exh_perr_even", {7'd0, if_e.par_err}, {7'd0, fl});
                chk("exh_perr_odd", {7'd0, if_o.par_err}, {7'd0, ~fl});
                step();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
